tx_fifo_feeder: RTL

TX_FIFO_FEEDER -- requirements
Module: tx_fifo_feeder

---
 rtl/tx_fifo_feeder_pkg.sv | 23 ++
 rtl/tx_fifo_feeder_if.sv | 40 ++++
 rtl/tx_byte_fifo.sv | 78 +++++++
 rtl/tx_fifo_feeder.sv | 98 +++++++++
 4 files changed

// File: rtl/tx_fifo_feeder_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tx_fifo_feeder_pkg : shared FSM encoding and size defaults for the feeder
// Revision: 1.0
// ---------------------------------------------------------------------------
package tx_fifo_feeder_pkg;

   localparam int DEPTH_DEFAULT  = 16;
   localparam int DATA_W_DEFAULT = 8;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_START     = 2'd1,
      ST_WAIT_DONE = 2'd2,
      ST_ACK       = 2'd3
   } feeder_state_t;

   function automatic int cnt_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/tx_fifo_feeder_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tx_fifo_feeder_if : write port, status and transmitter handshake bundle
// Revision: 1.0
// ---------------------------------------------------------------------------
interface tx_fifo_feeder_if
   import tx_fifo_feeder_pkg::*;
#(
   parameter int DEPTH  = DEPTH_DEFAULT,
   parameter int DATA_W = DATA_W_DEFAULT
);
   localparam int CNT_W = cnt_width(DEPTH);

   logic [DATA_W-1:0] wr_data;
   logic              wr_en;
   logic              fifo_full;
   logic              fifo_empty;
   logic [CNT_W-1:0]  fifo_count;
   logic              overflow;
   logic              clr_overflow;
   logic [DATA_W-1:0] tx_data;
   logic              tx_start;
   logic              tx_busy;
   logic              tx_complete_flag;
   logic              tx_complete_del_flag;

   modport slave (
      input  wr_data, wr_en, clr_overflow, tx_busy, tx_complete_flag,
      output fifo_full, fifo_empty, fifo_count, overflow,
             tx_data, tx_start, tx_complete_del_flag
   );

   modport master (
      output wr_data, wr_en, clr_overflow, tx_busy, tx_complete_flag,
      input  fifo_full, fifo_empty, fifo_count, overflow,
             tx_data, tx_start, tx_complete_del_flag
   );

endinterface
`default_nettype wire

// File: rtl/tx_byte_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tx_byte_fifo : circular byte FIFO with occupancy counter and sticky overflow
// Revision: 1.0
// ---------------------------------------------------------------------------
module tx_byte_fifo
   import tx_fifo_feeder_pkg::*;
#(
   parameter int DEPTH  = DEPTH_DEFAULT,
   parameter int DATA_W = DATA_W_DEFAULT,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = cnt_width(DEPTH)
) (
   input  logic              tx_clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic              clr_overflow,
   output logic [DATA_W-1:0] rd_data,
   output logic [CNT_W-1:0]  count,
   output logic              full,
   output logic              empty,
   output logic              overflow
);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic              w_pop;
   logic              w_push;
   logic              w_drop;
   logic [CNT_W-1:0]  w_count_next;

   // A pop frees a slot in the same cycle, so a write at full is still taken.
   assign w_pop   = rd_en && !empty;
   assign w_push  = wr_en && (!full || w_pop);
   assign w_drop  = wr_en && full && !w_pop;
   assign rd_data = r_mem[r_rd_ptr];

   always_comb begin
      w_count_next = count;
      if (w_push && !w_pop)
         w_count_next = count + CNT_W'(1);
      else if (!w_push && w_pop)
         w_count_next = count - CNT_W'(1);
   end

   always_ff @(posedge tx_clk) begin
      if (w_push)
         r_mem[r_wr_ptr] <= wr_data;
   end

   always_ff @(posedge tx_clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         count    <= '0;
         full     <= 1'b0;
         empty    <= 1'b1;
         overflow <= 1'b0;
      end else begin
         if (w_push)
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         count <= w_count_next;
         full  <= (w_count_next == CNT_W'(DEPTH));
         empty <= (w_count_next == '0);
         if (w_drop)
            overflow <= 1'b1;
         else if (clr_overflow)
            overflow <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: rtl/tx_fifo_feeder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tx_fifo_feeder : queues bytes and hands them one by one to the Transmitter
// Revision: 1.0
// ---------------------------------------------------------------------------
module tx_fifo_feeder
   import tx_fifo_feeder_pkg::*;
#(
   parameter int DEPTH  = DEPTH_DEFAULT,
   parameter int DATA_W = DATA_W_DEFAULT
) (
   input  logic            tx_clk,
   input  logic            reset,
   tx_fifo_feeder_if.slave bus
);

   feeder_state_t     r_state;
   logic              r_start;
   logic              r_del;
   logic [DATA_W-1:0] r_tx_data;
   logic [DATA_W-1:0] w_head;
   logic              w_pop;

   assign w_pop = (r_state == ST_IDLE) && !bus.fifo_empty &&
                  !bus.tx_busy && !bus.tx_complete_flag;

   tx_byte_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
   ) u_fifo (
      .tx_clk       (tx_clk),
      .reset        (reset),
      .wr_en        (bus.wr_en),
      .wr_data      (bus.wr_data),
      .rd_en        (w_pop),
      .clr_overflow (bus.clr_overflow),
      .rd_data      (w_head),
      .count        (bus.fifo_count),
      .full         (bus.fifo_full),
      .empty        (bus.fifo_empty),
      .overflow     (bus.overflow)
   );

   // tx_start lags entry into START by one cycle, giving the fixed write-to-start latency.
   always_ff @(posedge tx_clk or posedge reset) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_start   <= 1'b0;
         r_del     <= 1'b0;
         r_tx_data <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_start <= 1'b0;
               r_del   <= 1'b0;
               if (w_pop) begin
                  r_tx_data <= w_head;
                  r_state   <= ST_START;
               end
            end
            ST_START: begin
               if (bus.tx_busy) begin
                  r_start <= 1'b0;
                  r_state <= ST_WAIT_DONE;
               end else if (bus.tx_complete_flag) begin
                  r_start <= 1'b0;
                  r_del   <= 1'b1;
                  r_state <= ST_ACK;
               end else begin
                  r_start <= 1'b1;
               end
            end
            ST_WAIT_DONE: begin
               r_start <= 1'b0;
               if (bus.tx_complete_flag) begin
                  r_del   <= 1'b1;
                  r_state <= ST_ACK;
               end
            end
            ST_ACK: begin
               if (!bus.tx_complete_flag) begin
                  r_del   <= 1'b0;
                  r_state <= ST_IDLE;
               end else begin
                  r_del   <= 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.tx_start             = r_start;
   assign bus.tx_complete_del_flag = r_del;
   assign bus.tx_data              = r_tx_data;

endmodule
`default_nettype wire
